// File: rtl/gpio_in.sv
// Memory-mapped GPIO input port: 2-FF synchronizer, optional debounce, W1C edge flags and level IRQ.
// Define GPIO_IN_DEBOUNCE_EN to qualify each pin for DEBOUNCE_CYCLES stable cycles before acceptance.
module gpio_in #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       io_addr,
  input  logic              io_op,
  input  logic [3:0]        io_mask,
  input  logic [31:0]       io_wdata,
  output logic [31:0]       io_rdata,
  input  logic [WIDTH-1:0]  io_gpio,
  output logic              io_irq
);

  // IO bus handshake: there is no valid/ready pair. io_op is a single-cycle write strobe
  // that is always accepted on the next posedge; reads are combinational and side-effect free.

  logic [WIDTH-1:0] s1, s2, stable, rise, fall, irq_en;
  logic [WIDTH-1:0] accept, be, wdata;
  logic [WIDTH-1:0] set_rise, set_fall, clr_rise, clr_fall, en_wr;
  logic [1:0]       sel;

  assign sel   = io_addr[3:2];
  assign wdata = io_wdata[WIDTH-1:0];

  for (genvar g = 0; g < WIDTH; g++) begin : g_be
    assign be[g] = io_mask[g/8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= io_gpio;
      s2 <= s1;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Count consecutive cycles where the synchronized pin disagrees with the accepted level.
  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    logic [CW-1:0] cnt;
    assign accept[g] = (s2[g] != stable[g]) && (cnt == CNT_MAX);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt <= '0;
      else if ((s2[g] == stable[g]) || accept[g])
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, io_addr[31:4], io_addr[1:0], io_wdata, io_mask};
`else
  assign accept = s2 ^ stable;

  logic unused_ok;
  assign unused_ok = &{1'b0, io_addr[31:4], io_addr[1:0], io_wdata, io_mask, DEBOUNCE_CYCLES[0]};
`endif

  assign set_rise = accept & s2;
  assign set_fall = accept & ~s2;
  assign clr_rise = (io_op && sel == 2'd1) ? (wdata & be) : '0;
  assign clr_fall = (io_op && sel == 2'd2) ? (wdata & be) : '0;
  assign en_wr    = (io_op && sel == 2'd3) ? be : '0;

  // Set is ORed in after the clear so a new edge is never lost to a simultaneous W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      irq_en <= '0;
    end else begin
      stable <= (stable & ~accept) | (s2 & accept);
      rise   <= (rise & ~clr_rise) | set_rise;
      fall   <= (fall & ~clr_fall) | set_fall;
      irq_en <= (irq_en & ~en_wr) | (wdata & en_wr);
    end
  end

  assign io_irq = |((rise | fall) & irq_en);

  always_comb begin
    io_rdata = '0;
    case (sel)
      2'd0:    io_rdata[WIDTH-1:0] = stable;
      2'd1:    io_rdata[WIDTH-1:0] = rise;
      2'd2:    io_rdata[WIDTH-1:0] = fall;
      default: io_rdata[WIDTH-1:0] = irq_en;
    endcase
  end

endmodule

// File: tb/tb_gpio_in.sv
// Self-checking bench for gpio_in: register reset, pin qualification latency, glitch filtering,
// W1C flags, IRQ enable, byte masks and asynchronous reset.
`timescale 1ns/100ps
module tb_gpio_in;

  localparam int WIDTH = 2;
  localparam int DC    = 16;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int LAT       = 2 + DC;
  localparam int MIN_PULSE = DC;
`else
  localparam int LAT       = 3;
  localparam int MIN_PULSE = 1;
`endif
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_RISE = 2'd1;
  localparam logic [1:0] A_FALL = 2'd2;
  localparam logic [1:0] A_IEN  = 2'd3;

  logic             clk;
  logic             rst_n;
  logic [31:0]      io_addr;
  logic             io_op;
  logic [3:0]       io_mask;
  logic [31:0]      io_wdata;
  logic [31:0]      io_rdata;
  logic [WIDTH-1:0] io_gpio;
  logic             io_irq;

  logic [31:0] exp_q[$];
  logic [31:0] got, exp;
  int          n_checks = 0;
  int          n_fail   = 0;

  gpio_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_addr  (io_addr),
    .io_op    (io_op),
    .io_mask  (io_mask),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_gpio  (io_gpio),
    .io_irq   (io_irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- driver tasks (all called at a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    logic [31:0] r;
    r = $urandom();
    io_addr = {r[31:4], a, r[1:0]};
    #1;
    d = io_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = $urandom();
    io_addr  = {r[31:4], a, r[1:0]};
    io_wdata = d;
    io_mask  = m;
    io_op    = 1'b1;
    @(negedge clk);
    io_op    = 1'b0;
    io_wdata = $urandom();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; io_op = 1'b0; io_mask = 4'hf; io_wdata = '0; io_addr = '0;
    io_gpio = 2'b11;
    tick(3);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], got); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected %h", a, got, exp); end
    end
    exp = exp_q.pop_front(); n_checks++;
    if ({31'b0, io_irq} !== exp) begin n_fail++; $display("FAIL reset_irq: got %b expected %h", io_irq, exp); end
    io_gpio = 2'b00;
    tick(1);
    rst_n = 1'b1;
    tick(LAT + 2);
  endtask

  task automatic test_step;
    io_gpio = 2'b01;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    tick(LAT - 1);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL step_data_early: got %h expected %h", got, exp); end
    tick(1);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL step_data: got %h expected %h", got, exp); end
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL step_rise: got %h expected %h", got, exp); end
    rd(A_FALL, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL step_fall: got %h expected %h", got, exp); end
  endtask

  task automatic test_glitch;
    logic [31:0] flag;
    io_gpio = 2'b00;
    tick(LAT + 1);
    wr(A_RISE, 32'h3, 4'hf);
    wr(A_FALL, 32'h3, 4'hf);
    flag = (5 < MIN_PULSE) ? 32'h0 : 32'h1;
    io_gpio = 2'b01;
    tick(5);
    io_gpio = 2'b00;
    exp_q.push_back(32'h0);
    exp_q.push_back(flag);
    exp_q.push_back(flag);
    tick(LAT + 2);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", got, exp); end
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_rise: got %h expected %h", got, exp); end
    rd(A_FALL, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_fall: got %h expected %h", got, exp); end
    wr(A_RISE, 32'h3, 4'hf);
    wr(A_FALL, 32'h3, 4'hf);
    io_gpio = 2'b01;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    tick(LAT - 1);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL hold_data_early: got %h expected %h", got, exp); end
    tick(1);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL hold_data: got %h expected %h", got, exp); end
    tick(20 - LAT + 1);
  endtask

  task automatic test_irq;
    wr(A_RISE, 32'h3, 4'hf);
    wr(A_FALL, 32'h3, 4'hf);
    wr(A_IEN, 32'h1, 4'hf);
    io_gpio = 2'b11;
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    tick(LAT);
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL irq_rise: got %h expected %h", got, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({31'b0, io_irq} !== exp) begin n_fail++; $display("FAIL irq_masked: got %b expected %h", io_irq, exp); end
    wr(A_IEN, 32'h3, 4'hf);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if ({31'b0, io_irq} !== exp) begin n_fail++; $display("FAIL irq_enabled: got %b expected %h", io_irq, exp); end
  endtask

  task automatic test_w1c_collision;
    io_gpio = 2'b10;
    tick(LAT + 1);
    io_gpio = 2'b11;
    tick(LAT - 1);
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    wr(A_RISE, 32'h1, 4'hf);
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL w1c_set_wins: got %h expected %h", got, exp); end
    wr(A_RISE, 32'h1, 4'hf);
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL w1c_clear: got %h expected %h", got, exp); end
    wr(A_RISE, 32'h3, 4'h0);
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL w1c_masked: got %h expected %h", got, exp); end
    wr(A_RISE, 32'h3, 4'hf);
    wr(A_FALL, 32'h3, 4'hf);
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL w1c_all_clear: got %h expected %h", got, exp); end
    exp = exp_q.pop_front(); n_checks++;
    if ({31'b0, io_irq} !== exp) begin n_fail++; $display("FAIL irq_cleared: got %b expected %h", io_irq, exp); end
  endtask

  task automatic test_mask;
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h2);
    wr(A_IEN, 32'h0, 4'h0);
    rd(A_IEN, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL ien_mask0: got %h expected %h", got, exp); end
    wr(A_DATA, 32'h0, 4'hf);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL data_ro: got %h expected %h", got, exp); end
    wr(A_IEN, 32'h2, 4'h1);
    rd(A_IEN, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL ien_write: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid;
    io_gpio = 2'b01;
    exp_q.push_back(32'h1);
    tick(LAT);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if ({31'b0, io_irq} !== exp) begin n_fail++; $display("FAIL irq_fall: got %b expected %h", io_irq, exp); end
    io_gpio = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); n_checks++;
    if ({31'b0, io_irq} !== exp) begin n_fail++; $display("FAIL rst_irq: got %b expected %h", io_irq, exp); end
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(32'h0);
      rd(a[1:0], got); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL rst_mid_reg%0d: got %h expected %h", a, got, exp); end
    end
    tick(3);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h3);
    tick(LAT - 1);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_requal_early: got %h expected %h", got, exp); end
    tick(1);
    rd(A_DATA, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_requal_data: got %h expected %h", got, exp); end
    rd(A_RISE, got); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rst_requal_rise: got %h expected %h", got, exp); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_irq();
    test_w1c_collision();
    test_mask();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
